// File: rtl/unsigned_issue_ctrl.sv
// unsigned_issue_ctrl
// Sequential issue/capture stage wrapped around a combinational unsigned
// arithmetic unit. One operation (A, B, OpCode) is accepted at a time over a
// valid/ready handshake.
//
// The operands are held on registered outputs for a per-opcode number of
// settle cycles. The unit's Answer is then captured and offered downstream
// over a second valid/ready handshake. Because the operands stay stable for
// the whole settle window, the long multiply and divide paths can be
// constrained as multicycle paths.
//
// Ports
//   clk, reset           clock and synchronous active-high reset
//   in_valid, in_ready   upstream handshake
//   in_a, in_b, in_op    operation to issue (op: 00 add, 01 sub, 10 mul, 11 div)
//   op_a, op_b, op_code  registered operands driven to the arithmetic unit
//   unit_answer          combinational Answer returned by the unit
//   res_valid, res_ready downstream handshake
//   res_data, res_dz     captured result and divide-by-zero flag
//   busy                 high while an operation is settling or a result is held
module unsigned_issue_ctrl #(
   parameter int ADD_CYCLES = 1,
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   input  logic [1:0]  in_op,
   output logic [31:0] op_a,
   output logic [31:0] op_b,
   output logic [1:0]  op_code,
   input  logic [31:0] unit_answer,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic        res_dz,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   // The counter is loaded with N-1 so that it reaches zero on the cycle in
   // which the result is captured. This gives a latency of exactly N edges.
   localparam logic [7:0] ADD_LOAD = 8'(ADD_CYCLES - 1);
   localparam logic [7:0] MUL_LOAD = 8'(MUL_CYCLES - 1);
   localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);

   state_t      state;
   state_t      next_state;
   logic [7:0]  cnt;
   logic [7:0]  cnt_load;
   logic        accept;
   logic        capture;
   logic        div_by_zero;

   // Retiring the result in DONE frees the stage in the same cycle. This lets
   // a new operation be accepted on the retire edge.
   assign in_ready    = (state == IDLE) | ((state == DONE) & res_ready);
   assign accept      = in_valid & in_ready;
   assign capture     = (state == WAIT) && (cnt == 8'd0);
   assign div_by_zero = (op_code == 2'b11) && (op_b == 32'd0);
   assign busy        = (state == WAIT) | (state == DONE);

   // Settle time selected by the incoming opcode. Add and sub share a value.
   always_comb begin
      cnt_load = ADD_LOAD;
      case (in_op)
         2'b10:   cnt_load = MUL_LOAD;
         2'b11:   cnt_load = DIV_LOAD;
         default: cnt_load = ADD_LOAD;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (accept) next_state = WAIT;
         end
         WAIT: begin
            if (cnt == 8'd0) next_state = DONE;
         end
         DONE: begin
            if (res_valid && res_ready) next_state = accept ? WAIT : IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Operand registers, settle counter and result capture. A divide by zero
   // ignores whatever the unit returns and reports all-ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         op_a      <= 32'd0;
         op_b      <= 32'd0;
         op_code   <= 2'b00;
         cnt       <= 8'd0;
         res_data  <= 32'd0;
         res_dz    <= 1'b0;
         res_valid <= 1'b0;
      end else begin
         if (accept) begin
            op_a    <= in_a;
            op_b    <= in_b;
            op_code <= in_op;
            cnt     <= cnt_load;
         end else if ((state == WAIT) && (cnt != 8'd0)) begin
            cnt <= cnt - 8'd1;
         end

         if (capture) begin
            res_data  <= div_by_zero ? 32'hFFFF_FFFF : unit_answer;
            res_dz    <= div_by_zero;
            res_valid <= 1'b1;
         end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_unsigned_issue_ctrl.sv
// Directed testbench for unsigned_issue_ctrl. A small behavioural model of
// the arithmetic unit drives unit_answer from the DUT's registered operands.
module tb_unsigned_issue_ctrl;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic [1:0]  in_op;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [1:0]  op_code;
   logic [31:0] unit_answer;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic        res_dz;
   logic        busy;

   int testsRun    = 0;
   int testsFailed = 0;

   unsigned_issue_ctrl #(
      .ADD_CYCLES(1),
      .MUL_CYCLES(4),
      .DIV_CYCLES(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_a(in_a),
      .in_b(in_b),
      .in_op(in_op),
      .op_a(op_a),
      .op_b(op_b),
      .op_code(op_code),
      .unit_answer(unit_answer),
      .res_valid(res_valid),
      .res_ready(res_ready),
      .res_data(res_data),
      .res_dz(res_dz),
      .busy(busy)
   );

   // Free-running clock, 10 time-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in for the combinational unsigned unit. Divide by zero returns a
   // junk pattern, which the stage must override.
   always_comb begin
      unit_answer = 32'd0;
      case (op_code)
         2'b00: unit_answer = op_a + op_b;
         2'b01: unit_answer = op_a - op_b;
         2'b10: unit_answer = op_a * op_b;
         2'b11: unit_answer = (op_b == 32'd0) ? 32'h1234_5678 : op_a / op_b;
         default: unit_answer = 32'd0;
      endcase
   end

   // One comparison, counted, with a FAIL line on mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Advance one rising edge and settle at the following falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Present an operation from an idle stage and let it be accepted.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
      in_a     = a;
      in_b     = b;
      in_op    = op;
      in_valid = 1'b1;
      #1;
      checkOutput("in_ready before accept", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
   endtask

   // Count edges after the accept until res_valid rises. The wait is bounded,
   // and the operands must hold still throughout.
   task automatic waitResult(input string tag, input int expN, input logic [31:0] a,
                             input logic [31:0] b, input logic [1:0] op,
                             input logic [31:0] expData, input logic expDz);
      int cycles = 0;
      while (!res_valid && cycles < 50) begin
         checkOutput({tag, " op_a stable"}, op_a, a);
         checkOutput({tag, " op_b stable"}, op_b, b);
         checkOutput({tag, " op_code stable"}, {30'd0, op_code}, {30'd0, op}); 
         tick();
         cycles++;
      end
      checkOutput({tag, " latency"}, 32'(cycles), 32'(expN));
      checkOutput({tag, " res_data"}, res_data, expData);
      checkOutput({tag, " res_dz"}, {31'd0, res_dz}, {31'd0, expDz});
   endtask

   // Accept the held result with no new operation behind it.
   task automatic retire(input string tag);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      checkOutput({tag, " res_valid after retire"}, {31'd0, res_valid}, 32'd0);
      checkOutput({tag, " busy after retire"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_a      = 32'd0;
      in_b      = 32'd0;
      in_op     = 2'b00;
      res_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      checkOutput("reset res_valid", {31'd0, res_valid}, 32'd0);
      checkOutput("reset in_ready", {31'd0, in_ready}, 32'd1);
      checkOutput("reset busy", {31'd0, busy}, 32'd0);
      checkOutput("reset res_data", res_data, 32'd0);
      checkOutput("reset op_a", op_a, 32'd0);

      // T1: add, single settle cycle
      applyStimulus(32'd5, 32'd7, 2'b00);
      checkOutput("T1 busy in WAIT", {31'd0, busy}, 32'd1);
      checkOutput("T1 in_ready in WAIT", {31'd0, in_ready}, 32'd0);
      waitResult("T1", 1, 32'd5, 32'd7, 2'b00, 32'd12, 1'b0);
      retire("T1");

      // T2: multiply latency and truncation
      applyStimulus(32'h0001_0000, 32'h0001_0003, 2'b10);
      waitResult("T2", 4, 32'h0001_0000, 32'h0001_0003, 2'b10, 32'h0003_0000, 1'b0);
      retire("T2");

      // T3: divide by zero
      applyStimulus(32'd100, 32'd0, 2'b11);
      waitResult("T3", 8, 32'd100, 32'd0, 2'b11, 32'hFFFF_FFFF, 1'b1);
      retire("T3");

      // T4: backpressure while a new operation is stalled, then overlap
      applyStimulus(32'd9, 32'd4, 2'b01);
      waitResult("T4a", 1, 32'd9, 32'd4, 2'b01, 32'd5, 1'b0);
      in_a     = 32'd6;
      in_b     = 32'd7;
      in_op    = 2'b10;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         checkOutput("T4 stall in_ready", {31'd0, in_ready}, 32'd0);
         checkOutput("T4 hold res_valid", {31'd0, res_valid}, 32'd1);
         checkOutput("T4 hold res_data", res_data, 32'd5);
         checkOutput("T4 hold op_a", op_a, 32'd9);
         tick();
      end
      res_ready = 1'b1;
      #1;
      checkOutput("T4 in_ready with res_ready", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid  = 1'b0;
      res_ready = 1'b0;
      checkOutput("T4 retired res_valid", {31'd0, res_valid}, 32'd0);
      checkOutput("T4 back in WAIT busy", {31'd0, busy}, 32'd1);
      checkOutput("T4 back in WAIT in_ready", {31'd0, in_ready}, 32'd0);
      waitResult("T4b", 4, 32'd6, 32'd7, 2'b10, 32'd42, 1'b0);
      retire("T4b");

      // T5: reset in the middle of a division
      applyStimulus(32'd40, 32'd8, 2'b11);
      tick();
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("T5 res_valid", {31'd0, res_valid}, 32'd0);
      checkOutput("T5 in_ready", {31'd0, in_ready}, 32'd1);
      checkOutput("T5 busy", {31'd0, busy}, 32'd0);
      checkOutput("T5 op_a", op_a, 32'd0);
      checkOutput("T5 op_b", op_b, 32'd0);
      checkOutput("T5 op_code", {30'd0, op_code}, 32'd0);
      checkOutput("T5 res_data", res_data, 32'd0);
      checkOutput("T5 res_dz", {31'd0, res_dz}, 32'd0);
      for (int i = 0; i < 10; i++) begin
         tick();
         checkOutput("T5 no result emitted", {31'd0, res_valid}, 32'd0);
      end

      // T6: wraparound, plus an ordinary divide after reset
      applyStimulus(32'hFFFF_FFFF, 32'd1, 2'b00);
      waitResult("T6 add", 1, 32'hFFFF_FFFF, 32'd1, 2'b00, 32'd0, 1'b0);
      retire("T6 add");
      applyStimulus(32'd3, 32'd5, 2'b01);
      waitResult("T6 sub", 1, 32'd3, 32'd5, 2'b01, 32'hFFFF_FFFE, 1'b0);
      retire("T6 sub");
      applyStimulus(32'd40, 32'd8, 2'b11);
      waitResult("T6 div", 8, 32'd40, 32'd8, 2'b11, 32'd5, 1'b0);
      retire("T6 div");

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
